// File: rtl/sgpr_port_arbiter.sv
// sgpr_port_arbiter: shares the scalar regfile ports among
// operand fetchers (reads) and SALU/memory writeback (writes).
module sgpr_port_arbiter #(
  parameter int NUM_RD     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_RD-1:0]   rd_req,
  input  logic [8*NUM_RD-1:0] rd_addr0,
  input  logic [8*NUM_RD-1:0] rd_addr1,
  output logic [NUM_RD-1:0]   rd_gnt,
  output logic                rd_valid,
  output logic [2:0]          rd_id,
  output logic [63:0]         rd_data0,
  output logic [63:0]         rd_data1,
  input  logic                wb_req,
  input  logic                wb_64,
  input  logic [7:0]          wb_addr,
  input  logic [63:0]         wb_data,
  input  logic                mem_req,
  input  logic                mem_64,
  input  logic [7:0]          mem_addr,
  input  logic [63:0]         mem_data,
  output logic                wb_gnt,
  output logic                mem_gnt,
  input  logic [63:0]         rf_r0,
  input  logic [63:0]         rf_r1,
  output logic [7:0]          rf_s0,
  output logic [7:0]          rf_s1,
  output logic [7:0]          rf_w0,
  output logic [63:0]         rf_wv,
  output logic                rf_en_w,
  output logic                rf_en_64,
  output logic                wr_err,
  output logic [7:0]          wr_err_addr
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic [2:0]    ptr;
  logic          s_vld;
  logic [2:0]    s_id;

  logic          mem_pri;
  logic          w_go;
  logic          w_prot;
  logic          w_ok;
  logic [7:0]    w_addr;
  logic          w_64;
  logic [63:0]   w_data;

  logic          rd_hit;
  logic          rd_go;
  logic [2:0]    rd_win;
  logic [7:0]    win_a0;
  logic [7:0]    win_a1;

  function automatic logic ro(input logic [7:0] a);
    return (a == 8'h7D)
        || (a >= 8'h80 && a <= 8'hE8)
        || (a >= 8'hF0 && a <= 8'hF8);
  endfunction

  function automatic logic hit(
    input logic [7:0] x,
    input logic [7:0] w,
    input logic       w64
  );
    return (x == w) || (w64 && x == w + 8'd1);
  endfunction

  // a+1 is not part of a read footprint when a is the top address
  function automatic logic ovl(
    input logic [7:0] a0,
    input logic [7:0] a1,
    input logic [7:0] w,
    input logic       w64
  );
    return hit(a0, w, w64)
        || (a0 != 8'hFF && hit(a0 + 8'd1, w, w64))
        || hit(a1, w, w64)
        || (a1 != 8'hFF && hit(a1 + 8'd1, w, w64));
  endfunction

  assign mem_pri = mem_req
    && (!wb_req || starve_cnt == SW'(STARVE_MAX));
  assign mem_gnt = mem_pri;
  assign wb_gnt  = wb_req && !mem_pri;
  assign w_go    = wb_req || mem_req;

  // write winner mux and read-only check
  always_comb begin
    unique case (1'b1)
      mem_pri: begin
        w_addr = mem_addr;
        w_64   = mem_64;
        w_data = mem_data;
      end
      default: begin
        w_addr = wb_addr;
        w_64   = wb_64;
        w_data = wb_data;
      end
    endcase
    w_prot = ro(w_addr)
      || (w_64 && (w_addr == 8'hFF || ro(w_addr + 8'd1)));
    w_ok = w_go && !w_prot;
  end

  // round-robin pick: first pass from ptr up, then wrap
  always_comb begin
    rd_hit = 1'b0;
    rd_win = '0;
    win_a0 = '0;
    win_a1 = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (!rd_hit && rd_req[j] && 3'(j) >= ptr) begin
        rd_hit = 1'b1;
        rd_win = 3'(j);
        win_a0 = rd_addr0[8*j +: 8];
        win_a1 = rd_addr1[8*j +: 8];
      end
    end
    for (int j = 0; j < NUM_RD; j++) begin
      if (!rd_hit && rd_req[j] && 3'(j) < ptr) begin
        rd_hit = 1'b1;
        rd_win = 3'(j);
        win_a0 = rd_addr0[8*j +: 8];
        win_a1 = rd_addr1[8*j +: 8];
      end
    end
    rd_go = rd_hit
      && !(w_ok && ovl(win_a0, win_a1, w_addr, w_64));
  end

  // one-hot read grant
  always_comb begin
    rd_gnt = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (rd_go && rd_win == 3'(j)) rd_gnt[j] = 1'b1;
    end
  end

  assign rd_data0 = rf_r0;
  assign rd_data1 = rf_r1;

  // mem starvation counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (mem_req && !mem_pri) begin
      if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // write issue to regfile, rejected writes flag an error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_w0       <= '0;
      rf_wv       <= '0;
      rf_en_w     <= 1'b0;
      rf_en_64    <= 1'b0;
      wr_err      <= 1'b0;
      wr_err_addr <= '0;
    end else begin
      rf_en_w <= w_ok;
      wr_err  <= w_go && w_prot;
      if (w_go) begin
        rf_w0       <= w_addr;
        rf_wv       <= w_data;
        rf_en_64    <= w_64;
        wr_err_addr <= w_addr;
      end
    end
  end

  // read address issue and two-stage valid/id pipe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      rf_s0    <= '0;
      rf_s1    <= '0;
      s_vld    <= 1'b0;
      s_id     <= '0;
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      s_vld    <= rd_go;
      rd_valid <= s_vld;
      rd_id    <= s_id;
      if (rd_go) begin
        rf_s0 <= win_a0;
        rf_s1 <= win_a1;
        s_id  <= rd_win;
        if ({1'b0, rd_win} == 4'(NUM_RD - 1))
          ptr <= '0;
        else
          ptr <= rd_win + 3'd1;
      end
    end
  end

endmodule
